dma_timing_fsm: RTL

- Transfer-timing controller that sits directly downstream of dma_priority.
- Consumes the winning-channel request and produces the hold-request, DACK-enable, address and bus-strobe sequencing of one 8237A-style service (states SI, S0, S1, S2, S3, S4).
- Owns the current address/word-count datapath for the channel in service and writes it back to the register file when service ends.

---
 rtl/dma_timing_pkg.sv | 23 ++
 rtl/dma_addr_cnt.sv | 57 +++++
 rtl/dma_timing_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dma_timing_pkg.sv
// Shared types for the DMA transfer-timing controller.
//   state_e : service sequencing states (SI idle, S0 hold request, S1-S4 transfer, CASC cascade)
//   mode_e  : channel transfer mode
//   xfer_e  : transfer direction (illegal code maps to verify)
package dma_timing_pkg;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4, CASC} state_e;

  typedef enum logic [1:0] {
    MODE_DEMAND  = 2'b00,
    MODE_SINGLE  = 2'b01,
    MODE_BLOCK   = 2'b10,
    MODE_CASCADE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    XFER_VERIFY  = 2'b00,
    XFER_WRITE   = 2'b01,
    XFER_READ    = 2'b10,
    XFER_ILLEGAL = 2'b11
  } xfer_e;

endpackage

// File: rtl/dma_addr_cnt.sv
// Current address / word-count datapath for the channel in service.
//   load         : capture addr_in/cnt_in (start of service)
//   advance      : step address by +/-1 and count by -1 (exit of S4)
//   dec          : 1 = decrement address
//   reload       : select base registers for write-back (autoinit)
//   addr         : current transfer address
//   tc_flag      : count is zero, this transfer is the terminal one
//   upper_chg    : the next address differs in bits [ADDR_W-1:8]
//   wb_addr/cnt  : values to write back if service ends now
module dma_addr_cnt #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              advance,
  input  logic              dec,
  input  logic              reload,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [CNT_W-1:0]  base_cnt_in,
  output logic [ADDR_W-1:0] addr,
  output logic              tc_flag,
  output logic              upper_chg,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [CNT_W-1:0]  wb_cnt
);

  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      addr_q <= addr_in;
      cnt_q  <= cnt_in;
    end else if (advance) begin
      addr_q <= addr_next;
      cnt_q  <= cnt_next;
    end
  end

  always_comb begin
    addr_next = dec ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    cnt_next  = cnt_q - CNT_W'(1);
    tc_flag   = (cnt_q == '0);
    upper_chg = (addr_next[ADDR_W-1:8] != addr_q[ADDR_W-1:8]);
    wb_addr   = reload ? base_addr_in : addr_next;
    wb_cnt    = reload ? base_cnt_in : cnt_next;
    addr      = addr_q;
  end

endmodule

// File: rtl/dma_timing_fsm.sv
// 8237A-style transfer-timing controller for one granted channel.
//   inputs : CLK, RESET, valid_dreq, chan_sel, dreq_hold, mode, xfer_type, autoinit, addr_dec,
//            cur/base address and count of chan_sel, HLDA, READY, EOP_N_in
//   outputs: hrq, validDACK, AEN, ADSTB, addr, MEMR_N/MEMW_N/IOR_N/IOW_N, EOP_N_out, tc,
//            write-back strobe wb_valid with wb_chan/wb_addr/wb_cnt
module dma_timing_fsm
  import dma_timing_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              valid_dreq,
  input  logic [1:0]        chan_sel,
  input  logic              dreq_hold,
  input  logic [1:0]        mode,
  input  logic [1:0]        xfer_type,
  input  logic              autoinit,
  input  logic              addr_dec,
  input  logic [ADDR_W-1:0] cur_addr_in,
  input  logic [CNT_W-1:0]  cur_cnt_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [CNT_W-1:0]  base_cnt_in,
  input  logic              HLDA,
  input  logic              READY,
  input  logic              EOP_N_in,
  output logic              hrq,
  output logic              validDACK,
  output logic              AEN,
  output logic              ADSTB,
  output logic [ADDR_W-1:0] addr,
  output logic              MEMR_N,
  output logic              MEMW_N,
  output logic              IOR_N,
  output logic              IOW_N,
  output logic              EOP_N_out,
  output logic              tc,
  output logic              wb_valid,
  output logic [1:0]        wb_chan,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [CNT_W-1:0]  wb_cnt
);

  state_e     state_q, state_d;
  logic [1:0] chan_q;
  mode_e      mode_q;
  xfer_e      xfer_q;
  logic       autoinit_q, dec_q, eop_q;

  logic latch, tc_flag, upper_chg, ext_end, svc_end, reload, rd_phase, wr_phase;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= SI;
      chan_q     <= 2'b00;
      mode_q     <= MODE_DEMAND;
      xfer_q     <= XFER_VERIFY;
      autoinit_q <= 1'b0;
      dec_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        chan_q     <= chan_sel;
        mode_q     <= mode_e'(mode);
        xfer_q     <= (xfer_type == XFER_ILLEGAL) ? XFER_VERIFY : xfer_e'(xfer_type);
        autoinit_q <= autoinit;
        dec_q      <= addr_dec;
      end
      // Remember an external EOP seen early in the transfer; it ends service at S4.
      if (state_q == SI || state_q == S4) begin
        eop_q <= 1'b0;
      end else if ((state_q == S2 || state_q == S3) && !EOP_N_in) begin
        eop_q <= 1'b1;
      end
    end
  end

  dma_addr_cnt #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_addr_cnt (
    .CLK         (CLK),
    .RESET       (RESET),
    .load        (latch),
    .advance     (state_q == S4),
    .dec         (dec_q),
    .reload      (reload),
    .addr_in     (cur_addr_in),
    .cnt_in      (cur_cnt_in),
    .base_addr_in(base_addr_in),
    .base_cnt_in (base_cnt_in),
    .addr        (addr),
    .tc_flag     (tc_flag),
    .upper_chg   (upper_chg),
    .wb_addr     (wb_addr),
    .wb_cnt      (wb_cnt)
  );

  always_comb begin
    latch   = (state_q == SI) && valid_dreq;
    ext_end = eop_q || !EOP_N_in;
    svc_end = tc_flag || ext_end || (mode_q == MODE_SINGLE) ||
              ((mode_q == MODE_DEMAND) && !dreq_hold);
    // Autoinit reloads on any end-of-process (TC or external EOP), not on a mode stop.
    reload  = autoinit_q && (tc_flag || ext_end);

    state_d = state_q;
    unique case (state_q)
      SI:      if (valid_dreq) state_d = S0;
      S0:      if (HLDA) state_d = (mode_q == MODE_CASCADE) ? CASC : S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      if (READY) state_d = S4;
      S4:      state_d = svc_end ? SI : (upper_chg ? S1 : S2);
      CASC:    if (!dreq_hold) state_d = SI;
      default: state_d = SI;
    endcase
  end

  always_comb begin
    rd_phase  = (state_q == S2) || (state_q == S3) || (state_q == S4);
    wr_phase  = (state_q == S3) || (state_q == S4);
    hrq       = (state_q != SI);
    validDACK = rd_phase || (state_q == CASC);
    AEN       = (state_q == S1) || rd_phase;
    ADSTB     = (state_q == S1);
    MEMR_N    = !(rd_phase && xfer_q == XFER_READ);
    IOR_N     = !(rd_phase && xfer_q == XFER_WRITE);
    IOW_N     = !(wr_phase && xfer_q == XFER_READ);
    MEMW_N    = !(wr_phase && xfer_q == XFER_WRITE);
    tc        = (state_q == S4) && tc_flag && !RESET;
    EOP_N_out = !tc;
    wb_valid  = (state_q == S4) && svc_end && !RESET;
    wb_chan   = chan_q;
  end

endmodule
